// File: rtl/seq_mult_param_if.sv
// Bus bundle for seq_mult_param: START/READY handshake, operands, product and counter flags.
// With SEQ_MULT_SIGNED_EN defined the bundle also carries the TC (two's-complement) select.
interface seq_mult_param_if #(
  parameter int WIDTH = 4
);
  // Handshake: START is sampled at every rising edge and is always accepted,
  // loading A/B (and TC) and restarting any operation in flight.
  // READY=1 means idle with P holding the last completed product;
  // READY=0 means busy and P shows the partial shift register.
  logic                 START;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
`ifdef SEQ_MULT_SIGNED_EN
  logic                 TC;
`endif
  logic [2*WIDTH-1:0]   P;
  logic                 READY;
  logic                 CNTVCO2;
  logic                 CNTVCON2;
  logic                 state_dbg;

  modport master (
    output START, A, B,
`ifdef SEQ_MULT_SIGNED_EN
    output TC,
`endif
    input  P, READY, CNTVCO2, CNTVCON2, state_dbg
  );

  modport slave (
    input  START, A, B,
`ifdef SEQ_MULT_SIGNED_EN
    input  TC,
`endif
    output P, READY, CNTVCO2, CNTVCON2, state_dbg
  );
endinterface

// File: rtl/seq_mult_param.sv
// Parametrised shift-add sequential multiplier, WIDTH iterations per product, one adder.
// Optional SEQ_MULT_SIGNED_EN adds the TC input and a subtract path for two's-complement products.
module seq_mult_param #(
  parameter int WIDTH = 4
) (
  input  logic              blif_clk_net,
  input  logic              blif_reset_net,
  seq_mult_param_if.slave   bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH:0]     acc_q;
  logic [WIDTH-1:0]   mplr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               tc_q;
  logic               last_iter;

  logic               ext;
  logic               do_sub;
  logic [WIDTH+1:0]   acc_x;
  logic [WIDTH+1:0]   add_x;
  logic [WIDTH+1:0]   sum;

  assign last_iter = (cnt_q == LAST_CNT);

  // State register
  always_ff @(posedge blif_clk_net) begin
    if (blif_reset_net) state_q <= IDLE;
    else                state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (bus.START)                         state_d = BUSY;
    else if (state_q == BUSY && last_iter) state_d = IDLE;
  end

  // Iteration adder. acc is kept one bit wider than the operand so the signed
  // path can sign-extend; in unsigned mode its top bit stays zero.
  always_comb begin
    ext    = tc_q & mcand_q[WIDTH-1];
`ifdef SEQ_MULT_SIGNED_EN
    do_sub = tc_q & last_iter & mplr_q[0];
`else
    do_sub = 1'b0;
`endif
    acc_x  = {acc_q[WIDTH], acc_q};
    add_x  = mplr_q[0] ? {ext, ext, mcand_q} : '0;
    if (do_sub) add_x = ~add_x + {{(WIDTH+1){1'b0}}, 1'b1};
    sum    = acc_x + add_x;
  end

  always_ff @(posedge blif_clk_net) begin
    if (blif_reset_net) begin
      mcand_q <= '0;
      acc_q   <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
      tc_q    <= 1'b0;
    end else if (bus.START) begin
      mcand_q <= bus.A;
      acc_q   <= '0;
      mplr_q  <= bus.B;
      cnt_q   <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      tc_q    <= bus.TC;
`else
      tc_q    <= 1'b0;
`endif
    end else if (state_q == BUSY) begin
      // Shift {sum, mplr} right by one; sum's top bit is the carry or sign.
      acc_q  <= sum[WIDTH+1:1];
      mplr_q <= {sum[0], mplr_q[WIDTH-1:1]};
      cnt_q  <= last_iter ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Outputs
  always_comb begin
    bus.P         = {acc_q[WIDTH-1:0], mplr_q};
    bus.READY     = (state_q == IDLE);
    bus.CNTVCO2   = (state_q == BUSY) && last_iter;
    bus.CNTVCON2  = !((state_q == BUSY) && last_iter);
    bus.state_dbg = state_q;
  end
endmodule

// File: doc/seq_mult_param.md
# seq_mult_param

Parametrised sequential shift-add multiplier, the generalised successor of the fixed 4x4 START/READY multiplier in the benchmark set. It multiplies two WIDTH-bit operands in WIDTH iteration cycles using one adder, and exposes the same START/READY handshake and iteration-counter carry flags. The block is a drop-in sequential-datapath benchmark for timing and CTS experiments at scalable sizes.

## Interface
- WIDTH, 4, operand width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, never overridden.

- blif_clk_net  input  1  single clock; all state is updated on the rising edge.
- blif_reset_net  input  1  reset, synchronous and active-high.
- START  input  1  starts a multiply; sampled at every rising edge.
- A  input  WIDTH  multiplicand; sampled only at the edge where START is accepted.
- B  input  WIDTH  multiplier; sampled only at the edge where START is accepted.
- TC  input  1  two's-complement mode; sampled with A and B. Present only with SEQ_MULT_SIGNED_EN.
- P  output  2*WIDTH  product register.
- READY  output  1  high when the block is idle and P holds a completed result.
- CNTVCO2  output  1  counter carry-out; high during the final iteration cycle.
- CNTVCON2  output  1  always the complement of CNTVCO2.

## Operation
- The block has two states:
  - IDLE: READY=1.
  - BUSY: READY=0.
- Registers:
  - mcand (WIDTH bits), latched copy of A.
  - acc (WIDTH+1 bits), keeps the adder carry.
  - mplr (WIDTH bits).
  - cnt (CNT_W bits).
  - tc_q, latched copy of TC.
- P is {acc[WIDTH-1:0], mplr}.
- START=1 in any state (IDLE or BUSY) at a rising edge:
  - mcand<=A, mplr<=B, acc<=0, cnt<=0, tc_q<=TC.
  - The state becomes BUSY.
  - A START during BUSY aborts the current operation and restarts it with the new operands.
- BUSY with START=0, one iteration per edge:
  - sum = acc + (mplr[0] ? mcand : 0).
  - {acc, mplr} <= {carry/sign, sum, mplr} shifted right by one.
  - cnt <= cnt+1.
- Leaving BUSY: when cnt==WIDTH-1 at the edge, that iteration completes, the state becomes IDLE and cnt returns to 0.
- CNTVCO2 = (state==BUSY) && (cnt==WIDTH-1). This is combinational from registers.
- The product is exact modulo 2^(2*WIDTH). Unsigned overflow cannot occur.
- While BUSY, P shows the partial shift register. P is specified only while READY=1.
- In IDLE, P holds its value until the next accepted START.

## Timing
- Reset is asserted at an edge:
  - State becomes IDLE.
  - P=0, READY=1, CNTVCO2=0, CNTVCON2=1.
  - All internal registers are cleared.
- Reset takes priority over START.
- Reset asserted during BUSY aborts the operation. No partial result is retained.
- Latency: START is sampled at edge E0, and the state is BUSY after E0. Iterations run at E1..E_WIDTH.
- READY rises after edge E_WIDTH, with the final P valid in the same cycle.
- Back-to-back operation: START held high with READY=1 is accepted at the next edge.
- START held high continuously restarts the operation every edge, so READY stays 0.
- CNTVCO2 is high for exactly one cycle, the cycle between E_(WIDTH-1) and E_WIDTH.

## Configuration
- Macro: SEQ_MULT_SIGNED_EN.
- Defined:
  - The TC port exists.
  - With tc_q=1, the adder and shifter work on sign-extended WIDTH+1-bit values: the shift-in bit is the sum's sign, not the carry.
  - On the final iteration, when mplr[0] (the original B MSB) is 1, mcand is subtracted instead of added.
  - P is the two's-complement 2*WIDTH-bit product.
  - With tc_q=0, behaviour is identical to the unsigned build.
- Undefined: there is no TC port, operation is unsigned only, and there is no subtract path in the adder.

## Test plan
- Reset and basic product, WIDTH=4: reset; START with A=15, B=15.
  - READY=0 for 4 cycles.
  - CNTVCO2 is high in the 4th BUSY cycle only.
  - Then READY=1 and P=0xE1, held stable for 10 idle cycles.
- Zero operands, WIDTH=4: A=0, B=9 gives P=0x00; then A=9, B=0 gives P=0x00.
  - Both complete after 4 BUSY cycles.
- Restart, WIDTH=4: START with A=7, B=3.
  - After 2 BUSY cycles, START with A=5, B=6.
  - READY rises 4 edges after the second START, with P=0x1E.
- Reset mid-operation, WIDTH=8: START with A=255, B=255; assert reset in BUSY cycle 3.
  - Next cycle: READY=1, P=0.
  - A fresh START with A=255, B=255 gives P=0xFE01 after 8 cycles.
- Signed mode (SEQ_MULT_SIGNED_EN), WIDTH=4, TC=1:
  - A=-8, B=-8 gives P=0x40.
  - A=-8, B=7 gives P=0xC8.
  - A=3, B=-1 gives P=0xFD.
  - Repeating A=-8, B=-8 with TC=0 gives P=0x40 (unsigned 8*8).
- Exhaustive sweep, WIDTH=4: all 256 A/B pairs back-to-back, each START issued in the cycle READY=1.
  - P matches A*B for every pair (and the signed model when TC=1).
  - CNTVCON2 == ~CNTVCO2 every cycle.
